// File: rtl/me_pkg.sv
// Shared widths, ref-shift encodings and FSM states for the motion-estimation PE array feeder.
package me_pkg;
    localparam int PIXEL    = 8;
    localparam int X        = 32;
    localparam int Y        = 32;
    localparam int REF_ROWS = 8;
    localparam int ROW_BITS = X * PIXEL;
    localparam int CURR_W   = 2 * ROW_BITS;
    localparam int REF_W    = REF_ROWS * ROW_BITS;

    localparam logic [1:0] REF_HOLD   = 2'd0;
    localparam logic [1:0] REF_SHIFT1 = 2'd1;
    localparam logic [1:0] REF_SHIFT8 = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_CURR,
        ST_LOAD_REF,
        ST_SETTLE,
        ST_COMPARE,
        ST_SHIFT,
        ST_DONE
    } state_e;
endpackage

// File: rtl/feeder_out_stage.sv
// Registered PE-array data/enable stage: one cycle from accepted beat to pins.
// Enables pulse only for accepted beats; flush drops enables, data buses hold.
module feeder_out_stage
    import me_pkg::*;
#(
    parameter int PIXEL = me_pkg::PIXEL
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush_i,
    input  logic                        curr_load_i,
    input  logic [2*X*PIXEL-1:0]        curr_dat_i,
    input  logic                        ref_load_i,
    input  logic [1:0]                  ref_mode_i,
    input  logic [REF_ROWS*X*PIXEL-1:0] ref_dat_i,
    output logic [2*X*PIXEL-1:0]        curr_dat_o,
    output logic                        curr_en_o,
    output logic [REF_ROWS*X*PIXEL-1:0] ref_dat_o,
    output logic                        ref_chg_o,
    output logic [1:0]                  ref_ctl_o
);
    logic                        curr_take, ref_take;
    logic [2*X*PIXEL-1:0]        curr_dat_q;
    logic [REF_ROWS*X*PIXEL-1:0] ref_dat_q;
    logic                        curr_en_q, ref_chg_q;
    logic [1:0]                  ref_ctl_q;

    assign curr_take = curr_load_i & ~flush_i;
    assign ref_take  = ref_load_i & ~flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            curr_dat_q <= '0;
            ref_dat_q  <= '0;
            curr_en_q  <= 1'b0;
            ref_chg_q  <= 1'b0;
            ref_ctl_q  <= REF_HOLD;
        end else begin
            curr_en_q <= curr_take;
            ref_chg_q <= ref_take;
            ref_ctl_q <= ref_take ? ref_mode_i : REF_HOLD;
            if (curr_take) curr_dat_q <= curr_dat_i;
            if (ref_take)  ref_dat_q  <= ref_dat_i;
        end
    end

    assign curr_dat_o = curr_dat_q;
    assign curr_en_o  = curr_en_q;
    assign ref_dat_o  = ref_dat_q;
    assign ref_chg_o  = ref_chg_q;
    assign ref_ctl_o  = ref_ctl_q;
endmodule

// File: rtl/pe_array_feeder.sv
// Sequences current/reference loads into the 32x32 ME PE array and steps candidate rows.
// abs_valid/cand_* lag the COMPARE state by one cycle so they line up with abs_outs.
module pe_array_feeder
    import me_pkg::*;
#(
    parameter int SEARCH_ROWS = 64,
    parameter int CB_PASSES   = 4,
    parameter int PIXEL       = me_pkg::PIXEL,
    localparam int ROW_W      = $clog2(SEARCH_ROWS + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        cb_sel,
    input  logic                        curr_valid,
    output logic                        curr_ready,
    input  logic [2*X*PIXEL-1:0]        curr_data,
    input  logic                        ref_valid,
    output logic                        ref_ready,
    input  logic [REF_ROWS*X*PIXEL-1:0] ref_data,
    output logic [2*X*PIXEL-1:0]        current_64pixels,
    output logic                        in_curr_enable,
    output logic                        CB_select,
    output logic [1:0]                  abs_Control,
    output logic [REF_ROWS*X*PIXEL-1:0] ref_8R_32,
    output logic                        change_ref,
    output logic [1:0]                  ref_input_Control,
    output logic                        abs_valid,
    output logic [ROW_W-1:0]            cand_row,
    output logic [1:0]                  cand_cb,
    output logic                        busy,
    output logic                        done
);
    localparam logic [1:0]       LAST_PASS = 2'(CB_PASSES - 1);
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(SEARCH_ROWS);

    state_e           state_q;
    logic [4:0]       beat_q;
    logic [1:0]       pass_q;
    logic [ROW_W-1:0] row_q;
    logic [ROW_W-1:0] cand_row_q;
    logic [1:0]       abs_ctl_q;
    logic             cb_q, abs_valid_q, done_q;
    logic             curr_acc, ref_acc;

    // Ready is a pure function of state; abort still vetoes the transfer.
    assign curr_ready = (state_q == ST_LOAD_CURR);
    assign ref_ready  = (state_q == ST_LOAD_REF) || (state_q == ST_SHIFT);
    assign curr_acc   = curr_valid & curr_ready & ~abort;
    assign ref_acc    = ref_valid & ref_ready & ~abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            pass_q      <= '0;
            row_q       <= '0;
            cand_row_q  <= '0;
            abs_ctl_q   <= '0;
            cb_q        <= 1'b0;
            abs_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            abs_valid_q <= 1'b0;
            done_q      <= 1'b0;
            if (abort) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: if (start) begin
                        cb_q       <= cb_sel;
                        beat_q     <= '0;
                        pass_q     <= '0;
                        row_q      <= '0;
                        cand_row_q <= '0;
                        state_q    <= ST_LOAD_CURR;
                    end
                    ST_LOAD_CURR: if (curr_acc) begin
                        beat_q <= beat_q + 5'd1;
                        if (beat_q == 5'd31) state_q <= ST_LOAD_REF;
                    end
                    ST_LOAD_REF: if (ref_acc) begin
                        beat_q <= (beat_q == 5'd3) ? 5'd0 : beat_q + 5'd1;
                        if (beat_q == 5'd3) state_q <= ST_SETTLE;
                    end
                    ST_SETTLE: state_q <= ST_COMPARE;
                    ST_COMPARE: begin
                        abs_valid_q <= 1'b1;
                        abs_ctl_q   <= pass_q;
                        cand_row_q  <= row_q;
                        if (pass_q == LAST_PASS) begin
                            pass_q  <= '0;
                            state_q <= (row_q == LAST_ROW) ? ST_DONE : ST_SHIFT;
                        end else begin
                            pass_q <= pass_q + 2'd1;
                        end
                    end
                    ST_SHIFT: if (ref_acc) begin
                        row_q   <= row_q + 1'b1;
                        state_q <= ST_SETTLE;
                    end
                    ST_DONE: begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    feeder_out_stage #(.PIXEL(PIXEL)) u_out (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (abort),
        .curr_load_i (curr_acc),
        .curr_dat_i  (curr_data),
        .ref_load_i  (ref_acc),
        .ref_mode_i  ((state_q == ST_SHIFT) ? REF_SHIFT1 : REF_SHIFT8),
        .ref_dat_i   (ref_data),
        .curr_dat_o  (current_64pixels),
        .curr_en_o   (in_curr_enable),
        .ref_dat_o   (ref_8R_32),
        .ref_chg_o   (change_ref),
        .ref_ctl_o   (ref_input_Control)
    );

    assign CB_select   = cb_q;
    assign abs_Control = abs_ctl_q;
    assign cand_cb     = abs_ctl_q;
    assign abs_valid   = abs_valid_q;
    assign cand_row    = cand_row_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
endmodule

// File: tb/tb_pe_array_feeder.sv
// Directed bench for pe_array_feeder: full runs, stall, abort, async reset, start-while-busy.
module tb_pe_array_feeder;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0, abort = 1'b0, cb_sel = 1'b0;
    logic          curr_valid = 1'b0, ref_valid = 1'b0;
    logic          curr_ready, ref_ready;
    logic [511:0]  curr_data = '0;
    logic [2047:0] ref_data = '0;
    logic [511:0]  current_64pixels;
    logic          in_curr_enable, CB_select, change_ref, abs_valid, busy, done;
    logic [1:0]    abs_Control, ref_input_Control, cand_cb;
    logic [2047:0] ref_8R_32;
    logic [6:0]    cand_row;

    pe_array_feeder dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cb_sel(cb_sel),
        .curr_valid(curr_valid), .curr_ready(curr_ready), .curr_data(curr_data),
        .ref_valid(ref_valid), .ref_ready(ref_ready), .ref_data(ref_data),
        .current_64pixels(current_64pixels), .in_curr_enable(in_curr_enable),
        .CB_select(CB_select), .abs_Control(abs_Control), .ref_8R_32(ref_8R_32),
        .change_ref(change_ref), .ref_input_Control(ref_input_Control),
        .abs_valid(abs_valid), .cand_row(cand_row), .cand_cb(cand_cb),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_assert = 0, n_fail = 0;
    int cyc = 0, start_cyc = 0;
    int curr_idx, ref_idx, en_cnt, refout_cnt, sh8_cnt, sh1_cnt, abs_cnt, done_cnt;
    int gap_cnt, ord_bad, ref_bad, abs_bad, cb_bad, first_en, last_sh8, first_abs;
    int last_row;
    logic exp_cb;

    function automatic logic [511:0] mk_curr(int i);
        logic [511:0] v;
        for (int w = 0; w < 16; w++) v[w*32 +: 32] = {16'hC0DE ^ 16'(w), 16'(i)};
        return v;
    endfunction

    function automatic logic [2047:0] mk_ref(int i);
        logic [2047:0] v;
        for (int w = 0; w < 64; w++) v[w*32 +: 32] = {16'(i), 16'(w)} ^ 32'hA5A5_0000;
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        curr_idx = 0; ref_idx = 0; en_cnt = 0; refout_cnt = 0; sh8_cnt = 0; sh1_cnt = 0;
        abs_cnt = 0; done_cnt = 0; gap_cnt = 0; ord_bad = 0; ref_bad = 0; abs_bad = 0;
        cb_bad = 0; first_en = -1; last_sh8 = -1; first_abs = -1; last_row = -1;
        curr_data = mk_curr(0);
        ref_data  = mk_ref(0);
    endtask

    // One clock: predict acceptances, advance, then sample outputs 1ns after the edge.
    task automatic tick();
        bit ca, ra;
        logic [2047:0] er;
        ca = curr_valid && curr_ready && !abort && rst_n;
        ra = ref_valid && ref_ready && !abort && rst_n;
        @(posedge clk); #1;
        cyc++;
        if (ca) curr_idx++;
        if (ra) ref_idx++;
        curr_data = mk_curr(curr_idx);
        ref_data  = mk_ref(ref_idx);
        if (in_curr_enable) begin
            if (current_64pixels !== mk_curr(en_cnt)) ord_bad++;
            if (first_en < 0) first_en = cyc;
            en_cnt++;
        end else if (en_cnt > 0 && en_cnt < 32) gap_cnt++;
        if (change_ref) begin
            er = mk_ref(refout_cnt);
            if (ref_input_Control == 2'd2) begin
                if (ref_8R_32 !== er) ref_bad++;
                sh8_cnt++; last_sh8 = cyc;
            end else if (ref_input_Control == 2'd1) begin
                if (ref_8R_32[255:0] !== er[255:0]) ref_bad++;
                sh1_cnt++;
            end else ref_bad++;
            refout_cnt++;
        end else if (ref_input_Control != 2'd0) ref_bad++;
        if (abs_valid) begin
            if (cand_row !== 7'(abs_cnt / 4) || cand_cb !== 2'(abs_cnt % 4) ||
                abs_Control !== cand_cb) abs_bad++;
            if (first_abs < 0) first_abs = cyc;
            last_row = int'(cand_row);
            abs_cnt++;
        end
        if (done) done_cnt++;
        if (busy && CB_select !== exp_cb) cb_bad++;
    endtask

    task automatic run_full(input bit cb, input int stall_after, input bit spam, output int len);
        bit stalled;
        clr();
        stalled = 0;
        curr_valid = 1'b1; ref_valid = 1'b1;
        cb_sel = cb; exp_cb = cb;
        start = 1'b1; tick(); start = 1'b0;
        cb_sel = ~cb;
        start_cyc = cyc;
        while (done_cnt == 0 && cyc - start_cyc < 3000) begin
            if (stall_after >= 0 && !stalled && curr_idx == stall_after) begin
                curr_valid = 1'b0;
                repeat (5) tick();
                curr_valid = 1'b1;
                stalled = 1;
            end else begin
                if (spam && (cyc - start_cyc == 5 || cyc - start_cyc == 34 ||
                             cyc - start_cyc == 100)) start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
        len = cyc - start_cyc;
        tick();
    endtask

    int len_a, len_b;
    bit found;

    initial begin
        clr();
        exp_cb = 1'b0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_ready", {curr_ready, ref_ready}, 0);
        check("rst_enables", {in_curr_enable, change_ref, abs_valid, done}, 0);
        check("rst_ctl", {ref_input_Control, abs_Control, cand_cb}, 0);
        check("rst_cand_row", cand_row, 0);
        check("rst_cb_select", CB_select, 0);
        check("rst_curr_bus", current_64pixels === '0, 1);
        check("rst_ref_bus", ref_8R_32 === '0, 1);
        rst_n = 1'b1;
        tick(); tick();

        // Run A: cb_sel=1, streams always valid.
        run_full(1'b1, -1, 1'b0, len_a);
        check("A_enables", en_cnt, 32);
        check("A_first_en", first_en - start_cyc, 1);
        check("A_gap", gap_cnt, 0);
        check("A_order", ord_bad, 0);
        check("A_shift8", sh8_cnt, 4);
        check("A_last_sh8", last_sh8 - start_cyc, 36);
        check("A_abs_after_sh8", first_abs - last_sh8, 2);
        check("A_first_abs", first_abs - start_cyc, 38);
        check("A_abs_count", abs_cnt, 260);
        check("A_abs_seq", abs_bad, 0);
        check("A_last_row", last_row, 64);
        check("A_shift1", sh1_cnt, 64);
        check("A_ref_data", ref_bad, 0);
        check("A_done", done_cnt, 1);
        check("A_cb_select", cb_bad, 0);
        check("A_len", len_a, 426);
        check("A_idle_after", {busy, done}, 0);

        // Run C: curr stream stalls 5 cycles after beat 10.
        run_full(1'b0, 10, 1'b0, len_b);
        check("C_enables", en_cnt, 32);
        check("C_gap", gap_cnt, 5);
        check("C_order", ord_bad, 0);
        check("C_abs_count", abs_cnt, 260);
        check("C_cb_select", cb_bad, 0);
        check("C_len", len_b, 431);

        // Abort during COMPARE at candidate row 7.
        clr();
        exp_cb = 1'b0; cb_sel = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (abs_valid && cand_row == 7'd7) found = 1;
        end
        check("abort_reached_row7", found, 1);
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_outs", {change_ref, in_curr_enable, abs_valid, ref_input_Control}, 0);
        repeat (10) tick();
        check("abort_no_done", done_cnt, 0);
        check("abort_idle", {busy, curr_ready, ref_ready}, 0);

        // Async reset mid-LOAD_REF.
        clr();
        exp_cb = 1'b1; cb_sel = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (ref_idx == 2) found = 1;
        end
        check("rstm_in_load_ref", {found, ref_ready}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        check("rstm_busy", busy, 0);
        check("rstm_ready", {curr_ready, ref_ready}, 0);
        check("rstm_enables", {change_ref, in_curr_enable, ref_input_Control, CB_select}, 0);
        check("rstm_buses", (ref_8R_32 === '0) && (current_64pixels === '0), 1);
        @(negedge clk) rst_n = 1'b1;
        tick();
        run_full(1'b1, -1, 1'b0, len_b);
        check("rstm_rerun_abs", abs_cnt, 260);
        check("rstm_rerun_len", len_b, 426);
        check("rstm_rerun_done", done_cnt, 1);

        // start pulses while busy must not restart the search.
        run_full(1'b0, -1, 1'b1, len_b);
        check("busy_start_len", len_b, len_a);
        check("busy_start_abs", abs_cnt, 260);
        check("busy_start_en", en_cnt, 32);
        check("busy_start_done", done_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
